// File: rtl/raabb_pkg.sv
// Shared definitions for the ray/AABB slab-test datapath.
//   - FloPoCo exception-field encodings (top two bits of every operand)
//   - default operand width (exception + sign + 11-bit exponent + 21-bit fraction)
//   - tag carried alongside each in-flight compare
//   - per-requester state encoding for the compare arbiter
package raabb_pkg;

    localparam int OP_W = 35;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    // Wide enough for up to 8 requesters.
    localparam int ID_W = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            nan;
    } tag_t;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_t;

    function automatic logic is_nan(input logic [1:0] exc);
        return exc == EXC_NAN;
    endfunction

endpackage

// File: rtl/fp_compare_arbiter_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a rotating pointer.
// The search starts one past the last granted index; the pointer only moves
// when a grant is made. Reset value N-1 gives requester 0 first priority.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   req           request vector
//   grant         one-hot grant (all zero when nothing eligible)
//   grant_valid   any grant this cycle
//   grant_idx     binary index of the granted requester
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_q;

    // Offset 1..N from the pointer, wrapped without a modulo; for each offset
    // the matching index is found by comparison so no dynamic indexing is needed.
    always_comb begin
        int target;
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        target      = 0;
        for (int off = 1; off <= N; off++) begin
            target = int'(last_q) + off;
            if (target >= N) begin
                target = target - N;
            end
            for (int i = 0; i < N; i++) begin
                if (!grant_valid && req[i] && (i == target)) begin
                    grant_valid = 1'b1;
                    grant_idx   = IW'(i);
                    grant[i]    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= IW'(N - 1);
        end else if (grant_valid) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/fp_compare_arbiter.sv
// fp_compare_arbiter: shares one pipelined FP greater-or-equal unit among
// N_REQ requesters. One compare is issued per cycle at most, a tag pipe
// follows each compare to the unit's output, and the result is returned as a
// one-cycle pulse to the requester that asked for it.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake
//   req_a/req_b           packed operands, requester i at slice i
//   rsp_valid             one-hot result pulse
//   rsp_ge/rsp_nan        result and NaN flag, zero when no response
//   cmp_a/cmp_b/cmp_ge    external compare unit (result CMP_LAT cycles later)
//   busy                  compares in flight or outstanding
// Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i]
// and the arbiter picks i; req_ready[i] then stays low until the cycle after
// rsp_valid[i] pulses. Responses cannot be stalled.
module fp_compare_arbiter
    import raabb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = OP_W - 1,
    parameter int CMP_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*(WIDTH+1)-1:0] req_a,
    input  logic [N_REQ*(WIDTH+1)-1:0] req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic                       rsp_ge,
    output logic                       rsp_nan,
    output logic [WIDTH:0]             cmp_a,
    output logic [WIDTH:0]             cmp_b,
    input  logic                       cmp_ge,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_REQ);

    req_state_t         state_q [N_REQ];
    req_state_t         state_d [N_REQ];
    logic [N_REQ-1:0]   outstanding;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant_oh;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [WIDTH:0]     a_win;
    logic [WIDTH:0]     b_win;
    tag_t               new_tag;
    tag_t               tag_q [CMP_LAT+1];
    tag_t               tag_o;
    logic [N_REQ-1:0]   rsp_valid_d;
    logic               busy_d;

    // ---------------- per-requester state ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= REQ_IDLE;
            end
        end else begin
            state_q <= state_d;
        end
    end

    // Release happens in the response cycle itself, so the requester is
    // ready again one cycle after its pulse and cannot be re-granted early.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            state_d[i]     = state_q[i];
            outstanding[i] = (state_q[i] == REQ_WAIT);
            case (state_q[i])
                REQ_IDLE: if (grant_oh[i])  state_d[i] = REQ_WAIT;
                REQ_WAIT: if (rsp_valid[i]) state_d[i] = REQ_IDLE;
                default:                    state_d[i] = REQ_IDLE;
            endcase
        end
    end

    assign req_ready = ~outstanding;
    assign eligible  = req_valid & req_ready;

    // ---------------- arbitration ----------------
    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (eligible),
        .grant       (grant_oh),
        .grant_valid (grant_vld),
        .grant_idx   (grant_idx)
    );

    // ---------------- issue ----------------
    always_comb begin
        a_win = '0;
        b_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                a_win = req_a[i*(WIDTH+1) +: WIDTH+1];
                b_win = req_b[i*(WIDTH+1) +: WIDTH+1];
            end
        end
    end

    always_comb begin
        new_tag       = '0;
        new_tag.valid = grant_vld;
        new_tag.id    = ID_W'(grant_idx);
        new_tag.nan   = is_nan(a_win[WIDTH -: 2]) | is_nan(b_win[WIDTH -: 2]);
    end

    // Stage CMP_LAT lines up with cmp_ge for operands registered at stage 0.
    assign tag_o = tag_q[CMP_LAT];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = tag_o.valid && (tag_o.id == ID_W'(i));
        end
    end

    // Every in-flight tag also has its requester in WAIT, but both are
    // listed so busy never depends on that invariant.
    always_comb begin
        busy_d = new_tag.valid;
        for (int s = 0; s < CMP_LAT; s++) begin
            busy_d = busy_d | tag_q[s].valid;
        end
        for (int i = 0; i < N_REQ; i++) begin
            busy_d = busy_d | (state_d[i] == REQ_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s <= CMP_LAT; s++) begin
                tag_q[s] <= '0;
            end
            cmp_a     <= '0;
            cmp_b     <= '0;
            rsp_valid <= '0;
            rsp_ge    <= 1'b0;
            rsp_nan   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tag_q[0] <= new_tag;
            for (int s = 1; s <= CMP_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            if (grant_vld) begin
                cmp_a <= a_win;
                cmp_b <= b_win;
            end
            rsp_valid <= rsp_valid_d;
            rsp_ge    <= tag_o.valid & cmp_ge & ~tag_o.nan;
            rsp_nan   <= tag_o.valid & tag_o.nan;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fp_compare_arbiter.sv
// Self-checking bench for fp_compare_arbiter with a behavioural compare unit
// and a transaction-level reference model (grant times, ready times, due
// response cycles) kept in an expected queue.
module tb_fp_compare_arbiter;
  import raabb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 34;
  localparam int CMP_LAT = 3;
  localparam int W       = WIDTH + 1;
  localparam int EW      = 32 + N_REQ + 2;

  localparam logic [W-1:0] FP_ONE = 35'h2_7FE0_0000;
  localparam logic [W-1:0] FP_TWO = 35'h2_8000_0000;
  localparam logic [W-1:0] FP_NAN = 35'h6_0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a = '0;
  logic [N_REQ*W-1:0] req_b = '0;
  logic [N_REQ-1:0]   rsp_valid;
  logic               rsp_ge;
  logic               rsp_nan;
  logic [W-1:0]       cmp_a;
  logic [W-1:0]       cmp_b;
  logic               cmp_ge;
  logic               busy;

  fp_compare_arbiter #(
    .N_REQ   (N_REQ),
    .WIDTH   (WIDTH),
    .CMP_LAT (CMP_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ge    (rsp_ge),
    .rsp_nan   (rsp_nan),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_ge    (cmp_ge),
    .busy      (busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Numeric ordering key of a FloPoCo word: zero < normals by {exp,frac} < inf.
  function automatic longint fp_key(input logic [W-1:0] x);
    longint mag;
    case (x[W-1 -: 2])
      EXC_ZERO:   mag = 0;
      EXC_NORMAL: mag = 1 + longint'(x[31:0]);
      EXC_INF:    mag = 64'h2_0000_0000;
      default:    mag = 0;
    endcase
    return x[32] ? -mag : mag;
  endfunction

  function automatic logic fp_isnan(input logic [W-1:0] x);
    return x[W-1 -: 2] == EXC_NAN;
  endfunction

  // ---------------- compare unit model ----------------
  // Reports 1 for NaN inputs so the arbiter's forcing of rsp_ge is exercised.
  logic [CMP_LAT-1:0] ge_pipe = '0;
  assign cmp_ge = ge_pipe[CMP_LAT-1];
  always @(posedge clk) begin
    ge_pipe <= {ge_pipe[CMP_LAT-2:0],
                (fp_isnan(cmp_a) || fp_isnan(cmp_b)) ? 1'b1 : (fp_key(cmp_a) >= fp_key(cmp_b))};
  end

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  int            ecount = 0;
  int            m_last = N_REQ - 1;
  int            m_ready_at[N_REQ];
  logic [W-1:0]  m_cmp_a = '0;
  logic [W-1:0]  m_cmp_b = '0;

  always @(posedge clk) begin
    int win;
    int idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic e_nan;
    logic e_ge;
    logic [N_REQ-1:0] onehot;
    ecount++;
    win = -1;
    if (!rst) begin
      exp_q.delete();
      m_last = N_REQ - 1;
      for (int i = 0; i < N_REQ; i++) m_ready_at[i] = 0;
      m_cmp_a = '0;
      m_cmp_b = '0;
    end else begin
      for (int off = 1; off <= N_REQ; off++) begin
        idx = (m_last + off) % N_REQ;
        if (win < 0 && req_valid[idx] && m_ready_at[idx] <= ecount) win = idx;
      end
      if (win >= 0) begin
        a = req_a[win*W +: W];
        b = req_b[win*W +: W];
        e_nan = fp_isnan(a) || fp_isnan(b);
        e_ge  = !e_nan && (fp_key(a) >= fp_key(b));
        onehot = '0;
        onehot[win] = 1'b1;
        exp_q.push_back({32'(ecount + CMP_LAT + 1), onehot, e_ge, e_nan});
        m_ready_at[win] = ecount + CMP_LAT + 3;
        m_last  = win;
        m_cmp_a = a;
        m_cmp_b = b;
      end
    end
  end

  // Scoreboard: every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    logic [EW-1:0]    head;
    logic [N_REQ-1:0] e_v;
    logic             e_ge;
    logic             e_nan;
    logic [N_REQ-1:0] e_rdy;
    logic             e_busy;
    if (ecount > 0) begin
      e_v = '0; e_ge = 1'b0; e_nan = 1'b0; e_busy = 1'b0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (head[EW-1 -: 32] == 32'(ecount)) begin
          head = exp_q.pop_front();
          e_v   = head[N_REQ+1:2];
          e_ge  = head[1];
          e_nan = head[0];
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        e_rdy[i] = m_ready_at[i] <= ecount + 1;
        if (m_ready_at[i] > ecount + 1) e_busy = 1'b1;
      end
      check("rsp_valid", 64'(rsp_valid), 64'(e_v));
      check("rsp_ge",    64'(rsp_ge),    64'(e_ge));
      check("rsp_nan",   64'(rsp_nan),   64'(e_nan));
      check("req_ready", 64'(req_ready), 64'(e_rdy));
      check("busy",      64'(busy),      64'(e_busy));
      check("cmp_a",     64'(cmp_a),     64'(m_cmp_a));
      check("cmp_b",     64'(cmp_b),     64'(m_cmp_b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    tick(n);
    rst = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [1:0]  exc;
    logic [31:0] mag;
    int          sel;
    sel = int'($urandom_range(0, 9));
    exc = (sel < 7) ? EXC_NORMAL : (sel == 7) ? EXC_ZERO : (sel == 8) ? EXC_INF : EXC_NAN;
    // Small magnitude set so equal operands occur often.
    case ($urandom_range(0, 3))
      0: mag = FP_ONE[31:0];
      1: mag = FP_TWO[31:0];
      2: mag = 32'h7FE0_0001;
      default: mag = $urandom;
    endcase
    return {exc, 1'($urandom_range(0, 1)), mag};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    int last_grant_cyc;
    int gaps;
    logic prev_rdy;

    do_reset(3);
    check("reset_ready", 64'(req_ready), 64'({N_REQ{1'b1}}));
    check("reset_busy",  64'(busy), 64'd0);

    // Single request: 2.0 >= 1.0.
    set_req(0, FP_TWO, FP_ONE);
    tick(1);
    req_valid = '0;
    tick(8);

    // All four requesters valid from reset.
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, (i % 2) ? FP_ONE : FP_TWO, (i % 2) ? FP_TWO : FP_ONE);
    tick(2);
    rst = 1'b1;
    tick(30);
    req_valid = '0;
    tick(8);

    // Equal and reversed operands.
    set_req(1, FP_ONE, FP_ONE);
    set_req(3, FP_ONE, FP_TWO);
    tick(2);
    req_valid = '0;
    tick(8);

    // NaN operand on requester 2.
    set_req(2, FP_NAN, FP_ONE);
    tick(1);
    req_valid = '0;
    tick(8);

    // Reset while three compares are in flight.
    for (int i = 0; i < 3; i++) set_req(i, FP_TWO, FP_ONE);
    tick(3);
    req_valid = '0;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("midrst_ready", 64'(req_ready), 64'hF);
    check("midrst_busy",  64'(busy), 64'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid != '0) pulses++;
      tick(1);
    end
    check("midrst_no_rsp", 64'(pulses), 64'd0);

    // Back-to-back on requester 1: grants CMP_LAT+3 apart.
    set_req(1, FP_TWO, FP_TWO);
    last_grant_cyc = -1;
    gaps = 0;
    prev_rdy = req_ready[1];
    for (int c = 0; c < 24; c++) begin
      tick(1);
      if (prev_rdy && !req_ready[1]) begin
        if (last_grant_cyc >= 0) begin
          check("b2b_gap", 64'(ecount - last_grant_cyc), 64'(CMP_LAT + 3));
          gaps++;
        end
        last_grant_cyc = ecount;
      end
      prev_rdy = req_ready[1];
    end
    check("b2b_gap_count_ok", 64'(gaps >= 2), 64'd1);
    req_valid = '0;
    tick(8);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_a[i*W +: W] = rand_op();
        req_b[i*W +: W] = rand_op();
        req_valid[i]    = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
      else rst = 1'b1;
      tick(1);
    end
    rst = 1'b1;
    req_valid = '0;
    tick(10);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_busy",  64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
